seg_display_scanner: RTL

SEG_DISPLAY_SCANNER -- requirements
Module: seg_display_scanner

---
 rtl/seg_display_scanner_pkg.sv | 30 +++
 rtl/seg_display_scanner_if.sv | 33 +++
 rtl/seg_frame_buffer.sv | 47 ++++
 rtl/seg_display_scanner.sv | 103 ++++++++++
 4 files changed

// File: rtl/seg_display_scanner_pkg.sv
// Shared constants, types and helpers for the 6-digit segment scanner.
// No logic of its own: constants and a pure function only.
// Not applicable: no handshake lives here.
package seg_display_scanner_pkg;

  localparam int NUM_DIGITS           = 6;
  localparam int SEG_W                = 8;
  localparam int IDX_W                = 3;
  localparam int DEFAULT_DIV          = 1000;
  localparam int DEFAULT_BLANK_CYCLES = 4;

  // BLANK covers the dead time at the start of a slot, SHOW the lit part.
  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  typedef logic [SEG_W-1:0] seg_t;

  // Element 0 holds digit 0.
  typedef logic [NUM_DIGITS-1:0][SEG_W-1:0] seg_bank_t;

  // Active-high digit select for one digit index.
  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_DIGITS-1:0] one;
    one = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/seg_display_scanner_if.sv
// Bundles the scanner's control, segment inputs and display outputs.
// Pure wiring, no latency.
// No backpressure: load is a strobe that is always accepted.
interface seg_display_scanner_if;
  import seg_display_scanner_pkg::*;

  logic enable;
  logic load;
  seg_t seg_in0;
  seg_t seg_in1;
  seg_t seg_in2;
  seg_t seg_in3;
  seg_t seg_in4;
  seg_t seg_in5;
  seg_t                  seg_out;
  logic [NUM_DIGITS-1:0] digit_en;
  logic                  frame_done;

  // The driver of segment data and control.
  modport master (
    output enable, load,
    output seg_in0, seg_in1, seg_in2, seg_in3, seg_in4, seg_in5,
    input  seg_out, digit_en, frame_done
  );

  // The scanner itself.
  modport slave (
    input  enable, load,
    input  seg_in0, seg_in1, seg_in2, seg_in3, seg_in4, seg_in5,
    output seg_out, digit_en, frame_done
  );

endinterface

// File: rtl/seg_frame_buffer.sv
// Double-buffered segment store: shadow bank takes loads, active bank feeds the display.
// A load lands in shadow on the next edge; active changes only on commit or bypass.
// No backpressure: every load is accepted and the last one before a commit wins.
module seg_frame_buffer
  import seg_display_scanner_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      load,
  input  seg_bank_t load_dat,
  input  logic      commit,
  input  logic      bypass,
  output seg_bank_t active
);

  seg_bank_t shadow_q;
  seg_bank_t active_q;
  logic      pending_q;

  // Later assignments override earlier ones, so bypass (a load landing on the
  // commit cycle) wins over a commit of the older shadow contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      if (load) begin
        shadow_q  <= load_dat;
        pending_q <= 1'b1;
      end
      if (commit) begin
        if (pending_q) begin
          active_q <= shadow_q;
        end
        pending_q <= 1'b0;
      end
      if (bypass) begin
        active_q  <= load_dat;
        pending_q <= 1'b0;
      end
    end
  end

  assign active = active_q;

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexes six segment bytes onto one segment bus with per-slot dead time.
// Outputs are registered and show the slot position of the current cycle; enable/load act on the next edge.
// No backpressure: load is always accepted, new data takes effect at the next frame boundary.
module seg_display_scanner
  import seg_display_scanner_pkg::*;
#(
  parameter int DIV          = DEFAULT_DIV,
  parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset,
  seg_display_scanner_if.slave bus
);

  localparam int               CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_nxt;
  logic [IDX_W-1:0]      idx_q, idx_nxt;
  scan_state_t           state_q, state_nxt;
  seg_t                  seg_out_q, seg_out_nxt;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_nxt;
  logic                  frame_done_q, frame_done_nxt;

  seg_bank_t in_bank;
  seg_bank_t active_bank;
  logic      frame_last;

  assign in_bank = {bus.seg_in5, bus.seg_in4, bus.seg_in3,
                    bus.seg_in2, bus.seg_in1, bus.seg_in0};

  // The last cycle of digit 5 closes the frame. The following cycle is always
  // BLANK, so a bank swap on this edge can never reach the outputs mid-frame.
  assign frame_last = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

  seg_frame_buffer u_buf (
    .clock    (clock),
    .reset    (reset),
    .load     (bus.load),
    .load_dat (in_bank),
    .commit   (frame_last),
    .bypass   (bus.load && frame_last),
    .active   (active_bank)
  );

  // Next slot position, FSM transition and next registered outputs.
  always_comb begin
    cnt_nxt        = cnt_q;
    idx_nxt        = idx_q;
    state_nxt      = state_q;
    seg_out_nxt    = '0;
    digit_en_nxt   = '0;
    frame_done_nxt = 1'b0;

    if (!bus.enable) begin
      cnt_nxt = '0;
      idx_nxt = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_nxt = '0;
      idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_nxt = cnt_q + 1'b1;
    end

    case (state_q)
      BLANK:   if (bus.enable && (cnt_nxt >= CNT_BLANK)) state_nxt = SHOW;
      SHOW:    if (!bus.enable || (cnt_nxt < CNT_BLANK)) state_nxt = BLANK;
      default: state_nxt = BLANK;
    endcase

    if (state_nxt == SHOW) begin
      digit_en_nxt = digit_onehot(idx_nxt);
      seg_out_nxt  = active_bank[idx_nxt];
    end
    frame_done_nxt = bus.enable && (cnt_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);
  end

  // Slot counters, FSM state and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      state_q      <= BLANK;
      seg_out_q    <= '0;
      digit_en_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_nxt;
      idx_q        <= idx_nxt;
      state_q      <= state_nxt;
      seg_out_q    <= seg_out_nxt;
      digit_en_q   <= digit_en_nxt;
      frame_done_q <= frame_done_nxt;
    end
  end

  assign bus.seg_out    = seg_out_q;
  assign bus.digit_en   = digit_en_q;
  assign bus.frame_done = frame_done_q;

endmodule
